// File: rtl/mult8_acc_pkg.sv
// Shared defaults, width helper and accumulator state type for the product accumulator.
package mult8_acc_pkg;

   localparam int unsigned PROD_W_DEF  = 16;
   localparam int unsigned ACC_W_DEF   = 24;
   localparam int unsigned COUNT_N_DEF = 8;

   // Counter must hold the value COUNT_N itself, not just COUNT_N-1.
   function automatic int unsigned cnt_w(input int unsigned count_n);
      return $clog2(count_n + 1);
   endfunction

   typedef enum logic [0:0] {
      ACC_EMPTY = 1'b0,
      ACC_RUN   = 1'b1
   } acc_state_t;

endpackage

// File: rtl/mult8_prod_accum.sv
// Sums a stream of multiplier products into groups of COUNT_N (or shorter on in_last)
// and presents each group sum in a registered valid/ready output slot.
module mult8_prod_accum
   import mult8_acc_pkg::*;
#(
   parameter int unsigned PROD_W  = PROD_W_DEF,
   parameter int unsigned ACC_W   = ACC_W_DEF,
   parameter int unsigned COUNT_N = COUNT_N_DEF,
   parameter int unsigned CNT_W   = cnt_w(COUNT_N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_p,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   if (COUNT_N < 1) begin : g_bad_count
      $error("COUNT_N must be at least 1");
   end
   if (ACC_W < PROD_W) begin : g_bad_width
      $error("ACC_W must be at least PROD_W");
   end

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             r_out_valid;
   logic [ACC_W-1:0] r_out_acc;
   logic [CNT_W-1:0] r_out_count;
   logic             r_out_ovf;

   acc_state_t       w_state;
   logic [ACC_W-1:0] w_base;
   logic [ACC_W:0]   w_sum;
   logic [CNT_W-1:0] w_ncnt;
   logic             w_novf;
   logic             w_close;
   logic             w_in_fire;
   logic             w_out_fire;

   assign w_state    = (r_cnt == '0) ? ACC_EMPTY : ACC_RUN;
   assign in_ready   = ~r_out_valid | out_ready;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   // A fresh group ignores whatever is left in the accumulator registers.
   always_comb begin
      w_base  = (w_state == ACC_RUN) ? r_acc : '0;
      w_sum   = {1'b0, w_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_p};
      w_ncnt  = r_cnt + 1'b1;
      w_novf  = ((w_state == ACC_RUN) ? r_ovf : 1'b0) | w_sum[ACC_W];
      w_close = in_last | (w_ncnt == CNT_W'(COUNT_N));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_acc   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         if (w_out_fire) begin
            r_out_valid <= 1'b0;
         end
         // A close in the same cycle as out_fire reloads the slot with no bubble.
         if (w_in_fire) begin
            if (w_close) begin
               r_out_valid <= 1'b1;
               r_out_acc   <= w_sum[ACC_W-1:0];
               r_out_count <= w_ncnt;
               r_out_ovf   <= w_novf;
               r_acc       <= '0;
               r_cnt       <= '0;
               r_ovf       <= 1'b0;
            end else begin
               r_acc <= w_sum[ACC_W-1:0];
               r_cnt <= w_ncnt;
               r_ovf <= w_novf;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_acc   = r_out_acc;
   assign out_count = r_out_count;
   assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mult8_prod_accum.sv
// Bench for mult8_prod_accum: four instances with different COUNT_N/ACC_W, a shared
// expected-result queue filled on accepted products and drained on out_fire.
module tb_mult8_prod_accum;
   import mult8_acc_pkg::*;

   localparam int unsigned NDUT = 4;

   function automatic int unsigned cn_of(input int g);
      return (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 1 : 3;
   endfunction
   function automatic int unsigned aw_of(input int g);
      return (g == 3) ? 17 : 24;
   endfunction

   typedef struct {
      int          g;
      logic [23:0] acc;
      logic [2:0]  cnt;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid  [NDUT];
   logic        in_last   [NDUT];
   logic [15:0] in_p      [NDUT];
   logic        out_ready [NDUT];
   logic        in_ready  [NDUT];
   logic        out_valid [NDUT];
   logic        out_ovf   [NDUT];
   logic [23:0] out_acc   [NDUT];
   logic [2:0]  out_count [NDUT];

   exp_t            sb[$];
   longint unsigned m_acc [NDUT];
   int unsigned     m_cnt [NDUT];
   logic            m_ovf [NDUT];
   int              n_checks = 0;
   int              n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int unsigned CN = cn_of(g);
      localparam int unsigned AW = aw_of(g);
      localparam int unsigned CW = cnt_w(CN);
      logic [AW-1:0] w_acc;
      logic [CW-1:0] w_cnt;

      mult8_prod_accum #(
         .PROD_W (16),
         .ACC_W  (AW),
         .COUNT_N(CN)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid[g]),
         .in_ready (in_ready[g]),
         .in_p     (in_p[g]),
         .in_last  (in_last[g]),
         .out_valid(out_valid[g]),
         .out_ready(out_ready[g]),
         .out_acc  (w_acc),
         .out_count(w_cnt),
         .out_ovf  (out_ovf[g])
      );
      assign out_acc[g]   = 24'(w_acc);
      assign out_count[g] = 3'(w_cnt);
   end

   // Scoreboard drain: every out_fire must match the oldest expected group.
   always @(negedge clk) begin
      if (!rst) begin
         for (int g = 0; g < NDUT; g++) begin
            if (out_valid[g] && out_ready[g]) begin
               exp_t e;
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected dut%0d: got acc=%0d cnt=%0d, expected no result",
                           g, out_acc[g], out_count[g]);
               end else begin
                  e = sb.pop_front();
                  if (e.g != g || out_acc[g] !== e.acc || out_count[g] !== e.cnt ||
                      out_ovf[g] !== e.ovf) begin
                     n_fail++;
                     $display("FAIL sb_result dut%0d: got acc=%0d cnt=%0d ovf=%0b, expected dut%0d acc=%0d cnt=%0d ovf=%0b",
                              g, out_acc[g], out_count[g], out_ovf[g], e.g, e.acc, e.cnt, e.ovf);
                  end
               end
            end
         end
      end
   end

   task automatic model_clear();
      for (int g = 0; g < NDUT; g++) begin
         m_acc[g] = 0;
         m_cnt[g] = 0;
         m_ovf[g] = 1'b0;
      end
      sb.delete();
   endtask

   task automatic model_accept(input int g, input logic [15:0] p, input logic last);
      longint unsigned modv, sum;
      int unsigned     nc;
      logic            nov;
      exp_t            e;
      modv = 64'd1 << aw_of(g);
      sum  = ((m_cnt[g] == 0) ? 64'd0 : m_acc[g]) + longint'(p);
      nov  = ((m_cnt[g] == 0) ? 1'b0 : m_ovf[g]) | (sum >= modv);
      sum  = sum % modv;
      nc   = m_cnt[g] + 1;
      if (last || nc == cn_of(g)) begin
         e.g   = g;
         e.acc = 24'(sum);
         e.cnt = 3'(nc);
         e.ovf = nov;
         sb.push_back(e);
         m_acc[g] = 0;
         m_cnt[g] = 0;
         m_ovf[g] = 1'b0;
      end else begin
         m_acc[g] = sum;
         m_cnt[g] = nc;
         m_ovf[g] = nov;
      end
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the product.
   task automatic send(input int g, input logic [15:0] p, input logic last);
      int n = 0;
      in_valid[g] = 1'b1;
      in_p[g]     = p;
      in_last[g]  = last;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready[g] && n < 50);
      n_checks++;
      if (!in_ready[g]) begin
         n_fail++;
         $display("FAIL send_timeout dut%0d: in_ready=%0b after %0d cycles, expected 1", g,
                  in_ready[g], n);
      end else begin
         model_accept(g, p, last);
      end
      @(posedge clk);
      #1;
      in_valid[g] = 1'b0;
      in_last[g]  = 1'b0;
   endtask

   task automatic check_out(input string name, input int g, input logic v,
                            input logic [23:0] acc, input logic [2:0] cnt, input logic ovf);
      n_checks++;
      if (out_valid[g] !== v || out_acc[g] !== acc || out_count[g] !== cnt ||
          out_ovf[g] !== ovf) begin
         n_fail++;
         $display("FAIL %s dut%0d: got v=%0b acc=%0d cnt=%0d ovf=%0b, expected v=%0b acc=%0d cnt=%0d ovf=%0b",
                  name, g, out_valid[g], out_acc[g], out_count[g], out_ovf[g], v, acc, cnt, ovf);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
         check_out("reset_out", g, 1'b0, 24'd0, 3'd0, 1'b0);
         n_checks++;
         if (in_ready[g] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready dut%0d: got %0b, expected 1", g, in_ready[g]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_group();
      for (int i = 0; i < 3; i++) send(0, 16'd65025, 1'b0);
      @(negedge clk);
      check_out("full_group_pending", 0, 1'b0, 24'd0, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      send(0, 16'd65025, 1'b0);
      @(negedge clk);
      check_out("full_group", 0, 1'b1, 24'h3F804, 3'd4, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic test_last();
      send(0, 16'd100, 1'b0);
      send(0, 16'd200, 1'b1);
      @(negedge clk);
      check_out("last_two", 0, 1'b1, 24'd300, 3'd2, 1'b0);
      @(posedge clk);
      #1;
      send(0, 16'd7, 1'b1);
      @(negedge clk);
      check_out("last_single", 0, 1'b1, 24'd7, 3'd1, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      out_ready[1] = 1'b0;
      send(1, 16'd3, 1'b0);
      send(1, 16'd4, 1'b0);
      in_valid[1] = 1'b1;
      in_p[1]     = 16'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_out("bp_hold", 1, 1'b1, 24'd7, 3'd2, 1'b0);
         n_checks++;
         if (in_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready: got %0b, expected 0", in_ready[1]);
         end
      end
      @(posedge clk);
      #1;
      out_ready[1] = 1'b1;
      send(1, 16'd5, 1'b0);
      send(1, 16'd6, 1'b0);
      @(negedge clk);
      check_out("bp_second", 1, 1'b1, 24'd11, 3'd2, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      in_valid[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_p[2] = 16'(i + 1);
         @(negedge clk);
         if (i > 0) check_out("b2b_stream", 2, 1'b1, 24'(i), 3'd1, 1'b0);
         n_checks++;
         if (in_ready[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_in_ready: got %0b, expected 1", in_ready[2]);
         end else begin
            model_accept(2, 16'(i + 1), 1'b0);
         end
         @(posedge clk);
         #1;
      end
      in_valid[2] = 1'b0;
      @(negedge clk);
      check_out("b2b_last", 2, 1'b1, 24'd3, 3'd1, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 3; i++) send(3, 16'd65025, 1'b0);
      @(negedge clk);
      check_out("ovf_set", 3, 1'b1, 24'd64003, 3'd3, 1'b1);
      @(posedge clk);
      #1;
      send(3, 16'd1, 1'b0);
      send(3, 16'd2, 1'b0);
      send(3, 16'd3, 1'b0);
      @(negedge clk);
      check_out("ovf_clear", 3, 1'b1, 24'd6, 3'd3, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_group();
      send(0, 16'd10, 1'b0);
      send(0, 16'd20, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      check_out("mid_reset", 0, 1'b0, 24'd0, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) send(0, 16'd1, 1'b0);
      @(negedge clk);
      check_out("after_reset", 0, 1'b1, 24'd4, 3'd4, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
         in_valid[g]  = 1'b0;
         in_last[g]   = 1'b0;
         in_p[g]      = '0;
         out_ready[g] = 1'b1;
      end
      test_reset();
      test_full_group();
      test_last();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_reset_mid_group();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drained: got %0d results outstanding, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
